// File: rtl/mult_accumulator.sv
// ----------------------------------------------------------------------------
// mult_accumulator
//   Tail of a MAC datapath: sums a stream of unsigned products coming out of
//   the 5-stage 32x32 multiplier into a wide accumulator. Frames are closed
//   by in_last, or forcibly once MAX_TERMS terms have been summed. Each
//   closed frame is pushed into an OUT_DEPTH-entry result FIFO read through
//   a valid/ready handshake. The input is never back-pressured. A result
//   that arrives while the FIFO is full is dropped, and this sets the sticky
//   overflow_err.
//
// Optional feature macro: MULT_ACCUMULATOR_SATURATE_EN
//   When defined, an add that carries out of ACC_W clamps the sum to
//   all-ones for the rest of the frame. The clamp is reported on out_sat.
//   When undefined, sums wrap modulo 2^ACC_W and out_sat is tied to 0.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   in_valid     in   product valid
//   in_data      in   IN_W unsigned product
//   in_last      in   final term of the frame (qualified by in_valid)
//   out_valid    out  result FIFO non-empty
//   out_ready    in   consumer takes the head entry
//   out_data     out  ACC_W frame sum at the FIFO head
//   out_count    out  CNT_W number of terms in the head frame
//   out_sat      out  head frame saturated
//   busy         out  a frame is open
//   overflow_err out  sticky: a result was dropped on a full FIFO
//   clr_err      in   synchronous clear of overflow_err (a new drop wins)
// ----------------------------------------------------------------------------
module mult_accumulator #(
   parameter int IN_W      = 64,
   parameter int ACC_W     = 72,
   parameter int MAX_TERMS = 256,
   parameter int CNT_W     = 9,
   parameter int OUT_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat,
   output logic             busy,
   output logic             overflow_err,
   input  logic             clr_err
);

   localparam int              PTR_W    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_TERMS);
   localparam logic [PTR_W:0]   FULL_LVL = (PTR_W+1)'(OUT_DEPTH);

   typedef enum logic {IDLE, ACCUM} state_t;

`ifdef MULT_ACCUMULATOR_SATURATE_EN
   // Returns {sat, sum}. Once the frame has saturated it stays pinned.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] b,
                                              input logic             sat_in);
      logic [ACC_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (sat_in || s[ACC_W])
         sat_add = {1'b1, {ACC_W{1'b1}}};
      else
         sat_add = {1'b0, s[ACC_W-1:0]};
   endfunction
`else
   function automatic logic [ACC_W-1:0] wrap_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
      wrap_add = a + b;
   endfunction
`endif

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] count;
   logic [ACC_W-1:0] in_ext;
   logic [CNT_W-1:0] count_inc;
   logic [ACC_W-1:0] sum;

   logic             push_en;
   logic [ACC_W-1:0] push_data;
   logic [CNT_W-1:0] push_count;

   assign in_ext    = {{(ACC_W-IN_W){1'b0}}, in_data};
   assign count_inc = count + 1'b1;
   assign busy      = (state == ACCUM);

`ifdef MULT_ACCUMULATOR_SATURATE_EN
   logic acc_sat;
   logic sum_sat;
   logic push_sat;
   assign {sum_sat, sum} = sat_add(acc, in_ext, acc_sat);
`else
   assign sum = wrap_add(acc, in_ext);
`endif

   // ---- frame close decode: what (if anything) goes to the FIFO this beat
   always_comb begin
      push_en    = 1'b0;
      push_data  = sum;
      push_count = count_inc;
`ifdef MULT_ACCUMULATOR_SATURATE_EN
      push_sat   = sum_sat;
`endif
      if (in_valid) begin
         if (state == IDLE) begin
            if (in_last) begin
               push_en    = 1'b1;
               push_data  = in_ext;
               push_count = CNT_W'(1);
`ifdef MULT_ACCUMULATOR_SATURATE_EN
               push_sat   = 1'b0;
`endif
            end
         end else if (in_last || (count_inc == MAX_CNT)) begin
            push_en = 1'b1;
         end
      end
   end

   // ---- accumulator / frame FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
`ifdef MULT_ACCUMULATOR_SATURATE_EN
         acc_sat <= 1'b0;
`endif
      end else if (in_valid) begin
         case (state)
            IDLE: begin
               if (!in_last) begin
                  acc   <= in_ext;
                  count <= CNT_W'(1);
                  state <= ACCUM;
`ifdef MULT_ACCUMULATOR_SATURATE_EN
                  acc_sat <= 1'b0;
`endif
               end
            end
            ACCUM: begin
               if (push_en) begin
                  acc   <= '0;
                  count <= '0;
                  state <= IDLE;
`ifdef MULT_ACCUMULATOR_SATURATE_EN
                  acc_sat <= 1'b0;
`endif
               end else begin
                  acc   <= sum;
                  count <= count_inc;
`ifdef MULT_ACCUMULATOR_SATURATE_EN
                  acc_sat <= sum_sat;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---- result FIFO
   logic [ACC_W-1:0] data_mem  [OUT_DEPTH];
   logic [CNT_W-1:0] count_mem [OUT_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   level;
   logic             full;
   logic             pop;
   logic             wr_ok;
   logic             drop;

   assign full      = (level == FULL_LVL);
   assign out_valid = (level != '0);
   assign pop       = out_valid & out_ready;
   // A pop in the same cycle frees the slot being written, so a full FIFO
   // still accepts the push.
   assign wr_ok     = push_en & (~full | pop);
   assign drop      = push_en & full & ~pop;
   assign out_data  = data_mem[rd_ptr];
   assign out_count = count_mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         overflow_err <= 1'b0;
         for (int i = 0; i < OUT_DEPTH; i++) begin
            data_mem[i]  <= '0;
            count_mem[i] <= '0;
         end
      end else begin
         if (wr_ok) begin
            data_mem[wr_ptr]  <= push_data;
            count_mem[wr_ptr] <= push_count;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (drop)
            overflow_err <= 1'b1;
         else if (clr_err)
            overflow_err <= 1'b0;
      end
   end

`ifdef MULT_ACCUMULATOR_SATURATE_EN
   logic sat_mem [OUT_DEPTH];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < OUT_DEPTH; i++)
            sat_mem[i] <= 1'b0;
      end else if (wr_ok) begin
         sat_mem[wr_ptr] <= push_sat;
      end
   end
   assign out_sat = sat_mem[rd_ptr];
`else
   assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_mult_accumulator.sv
module tb_mult_accumulator;

   localparam int IN_W  = 64;
   localparam int ACC_W = 66;
   localparam int CNT_W = 9;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic [IN_W-1:0]  in_data = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [ACC_W-1:0] out_data;
   logic [CNT_W-1:0] out_count;
   logic             out_sat;
   logic             busy;
   logic             overflow_err;
   logic             clr_err = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [ACC_W-1:0] d;
      logic [CNT_W-1:0] c;
      logic             s;
   } exp_t;
   exp_t sb[$];

   mult_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .MAX_TERMS(256),
                      .CNT_W(CNT_W), .OUT_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_count(out_count), .out_sat(out_sat),
      .busy(busy), .overflow_err(overflow_err), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input logic [ACC_W-1:0] d, input int c, input logic s);
      exp_t e;
      e.d = d;
      e.c = CNT_W'(c);
      e.s = s;
      sb.push_back(e);
   endtask

   // One input beat, driven just after an edge and consumed by the next edge.
   task automatic beat(input logic [IN_W-1:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain_empty", 128'(sb.size()), 128'd0);
   endtask

   // Scoreboard consumer: compares every handshake against the queue head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 128'(out_data), 128'h0 - 1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_data", 128'(out_data), 128'(e.d));
            chk("sb_count", 128'(out_count), 128'(e.c));
            chk("sb_sat", 128'(out_sat), 128'(e.s));
         end
      end
   end

   initial begin
      // Reset state
      #1 rst = 1'b1;
      #1;
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_out_data", 128'(out_data), 128'd0);
      chk("rst_out_count", 128'(out_count), 128'd0);
      chk("rst_out_sat", 128'(out_sat), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_overflow", 128'(overflow_err), 128'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Asynchronous reset mid-frame discards the partial sum
      beat(64'd1, 1'b0);
      beat(64'd2, 1'b0);
      beat(64'd3, 1'b0);
      chk("midframe_busy", 128'(busy), 128'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_out_valid", 128'(out_valid), 128'd0);
      chk("async_rst_busy", 128'(busy), 128'd0);
      chk("async_rst_overflow", 128'(overflow_err), 128'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      expect_out(66'd12, 2, 1'b0);
      beat(64'd5, 1'b0);
      beat(64'd7, 1'b1);
      drain(10);

      // Basic 4-term frame, result visible one cycle after the last beat
      expect_out(66'h3_FFFFFFF8_00000004, 4, 1'b0);
      beat(64'hFFFFFFFE_00000001, 1'b0);
      beat(64'hFFFFFFFE_00000001, 1'b0);
      beat(64'hFFFFFFFE_00000001, 1'b0);
      beat(64'hFFFFFFFE_00000001, 1'b1);
      chk("basic_latency_valid", 128'(out_valid), 128'd1);
      chk("basic_latency_data", 128'(out_data), 128'h3_FFFFFFF8_00000004);
      drain(10);

      // Single-term frame from IDLE
      expect_out(66'd42, 1, 1'b0);
      beat(64'd42, 1'b1);
      chk("single_busy", 128'(busy), 128'd0);
      drain(10);

      // Forced close at 256 terms, then the next term opens a new frame
      expect_out(66'd256, 256, 1'b0);
      for (int i = 0; i < 256; i++) beat(64'd1, 1'b0);
      chk("forced_busy_after_close", 128'(busy), 128'd0);
      beat(64'd1, 1'b0);
      chk("forced_next_busy", 128'(busy), 128'd1);
      expect_out(66'd2, 2, 1'b0);
      beat(64'd1, 1'b1);
      drain(10);

      // Backpressure: third result dropped, head stays stable
      out_ready = 1'b0;
      expect_out(66'd1, 1, 1'b0);
      expect_out(66'd2, 1, 1'b0);
      beat(64'd1, 1'b1);
      beat(64'd2, 1'b1);
      beat(64'd3, 1'b1);
      chk("ovf_set", 128'(overflow_err), 128'd1);
      chk("ovf_head_valid", 128'(out_valid), 128'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("ovf_head_stable", 128'(out_data), 128'd1);
      chk("ovf_sticky", 128'(overflow_err), 128'd1);
      out_ready = 1'b1;
      drain(10);
      chk("ovf_drained_valid", 128'(out_valid), 128'd0);
      clr_err = 1'b1;
      @(posedge clk);
      #1;
      clr_err = 1'b0;
      chk("ovf_cleared", 128'(overflow_err), 128'd0);

      // Push and pop in the same cycle while full: no drop
      out_ready = 1'b0;
      expect_out(66'd10, 1, 1'b0);
      expect_out(66'd20, 1, 1'b0);
      expect_out(66'd30, 1, 1'b0);
      beat(64'd10, 1'b1);
      beat(64'd20, 1'b1);
      out_ready = 1'b1;
      beat(64'd30, 1'b1);
      drain(10);
      chk("full_pushpop_no_ovf", 128'(overflow_err), 128'd0);

      // clr_err coinciding with a new drop: set wins
      out_ready = 1'b0;
      expect_out(66'd4, 1, 1'b0);
      expect_out(66'd5, 1, 1'b0);
      beat(64'd4, 1'b1);
      beat(64'd5, 1'b1);
      clr_err = 1'b1;
      beat(64'd6, 1'b1);
      clr_err = 1'b0;
      chk("clr_vs_drop", 128'(overflow_err), 128'd1);
      out_ready = 1'b1;
      drain(10);
      clr_err = 1'b1;
      @(posedge clk);
      #1;
      clr_err = 1'b0;

      // 256 full-scale terms overflow a 66-bit accumulator
`ifdef MULT_ACCUMULATOR_SATURATE_EN
      expect_out({ACC_W{1'b1}}, 256, 1'b1);
`else
      expect_out(66'h3_FFFFFFFF_FFFFFF00, 256, 1'b0);
`endif
      for (int i = 0; i < 256; i++) beat({IN_W{1'b1}}, 1'b0);
      drain(10);

      // A normal frame afterwards must report no saturation
      expect_out(66'd9, 2, 1'b0);
      beat(64'd4, 1'b0);
      beat(64'd5, 1'b1);
      drain(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mult_accumulator.md
Name: mult_accumulator

Overview:
- Downstream consumer of the 5-stage 32x32 pipelined multiplier.
- Sums a stream of 64-bit products into a wide accumulator (dot-product / MAC tail).
- Frames are delimited by a last flag. Each completed sum is pushed into a small output buffer with a valid/ready handshake.
- The multiplier cannot stall, so this block never back-pressures its input. It drops the result and flags an error when the buffer is full.

Parameters:
- IN_W, 64, product width; matches the multiplier output.
- ACC_W, 72, accumulator and result width; 8 guard bits allow 256 full-scale terms.
- MAX_TERMS, 256, maximum terms per frame before forced close.
- CNT_W, 9, term counter width; must hold MAX_TERMS.
- OUT_DEPTH, 2, output buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  product valid; the caller aligns it with the multiplier's 5-cycle latency.
- in_data  in  IN_W  unsigned product.
- in_last  in  1  marks the final term of a frame; qualified by in_valid.
- out_valid  out  1  output buffer non-empty.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  ACC_W  frame sum at the buffer head.
- out_count  out  CNT_W  number of terms in the head frame.
- out_sat  out  1  head frame saturated; constant 0 unless SATURATE_EN is defined.
- busy  out  1  a frame is open, i.e. at least one term has been accepted without a close.
- overflow_err  out  1  sticky; set when a result is dropped because the buffer is full.
- clr_err  in  1  synchronous clear of overflow_err.

Behaviour:
- Reset (asynchronous, active-high):
  - acc=0, count=0, state=IDLE.
  - Buffer empty: out_valid=0, out_data=0, out_count=0, out_sat=0.
  - busy=0, overflow_err=0.
- FSM has two states, IDLE and ACCUM.
  - IDLE, in_valid & !in_last: acc<=in_data, count<=1, go to ACCUM.
  - IDLE, in_valid & in_last: single-term frame; push {in_data, count 1}; stay in IDLE.
  - ACCUM, in_valid & !in_last & count+1<MAX_TERMS: acc<=acc+in_data, count<=count+1.
  - ACCUM, in_valid & (in_last or count+1==MAX_TERMS): push {acc+in_data, count+1}; acc<=0, count<=0, go to IDLE. This is a forced close when in_last=0.
  - in_valid=0 in either state: hold acc, count and state.
- Arithmetic:
  - Unsigned; in_data is zero-extended to ACC_W.
  - Without SATURATE_EN, the sum wraps modulo 2^ACC_W.
- Latency: the closing beat at cycle N produces out_valid=1 at cycle N+1 if the buffer was empty. out_data is driven from a register.
- Output buffer: OUT_DEPTH-entry FIFO.
  - Pop occurs when out_valid & out_ready.
  - Head entry and out_data are stable while out_valid=1 and out_ready=0.
- Boundary conditions:
  - Push while full with no pop in the same cycle: result dropped, overflow_err<=1, accumulator still clears.
  - Push and pop in the same cycle while full: both succeed; no drop.
  - Push and pop in the same cycle while empty: the entry is written; out_valid rises the next cycle (no bypass).
  - Write/read pointers wrap modulo OUT_DEPTH.
  - clr_err and a new drop in the same cycle: overflow_err stays 1 (set wins).
  - Reset mid-frame: partial sum and buffered results are discarded.
- busy = (state==ACCUM).

Optional Feature:
- Macro: MULT_ACCUMULATOR_SATURATE_EN.
- When defined:
  - Any add that carries out of ACC_W clamps acc to all-ones and sets a per-frame sat bit.
  - Further adds in that frame keep acc at all-ones.
  - The sat bit is stored with the entry and presented on out_sat; it clears at frame close.
- When undefined:
  - Modulo wrap, no sat logic is synthesised, and out_sat is tied to 0.

Test Plan:
- Reset: assert rst asynchronously mid-frame after 3 terms -> out_valid=0, busy=0, overflow_err=0 immediately; the next frame 5,7(last) -> out_data=12, out_count=2.
- Basic frame: terms 0xFFFFFFFE00000001 x4, last on the 4th, out_ready=1 -> out_data=0x3_FFFFFFF800000004 one cycle after the last beat; out_count=4.
- Single-term frame: in_valid & in_last with in_data=42 from IDLE -> out_data=42, out_count=1, busy stays 0.
- Forced close: 256 terms of value 1 with in_last=0 -> out_data=256, out_count=256. A 257th term starts a new frame; busy=1.
- Backpressure/overflow: out_ready=0, three back-to-back single-term frames 1,2,3 -> buffer holds 1,2; 3 is dropped and overflow_err=1. Then raise out_ready -> pops 1 then 2. Pulse clr_err -> overflow_err=0.
- Saturation (with macro): 256 terms of all-ones in ACC_W=66 build -> out_data=all-ones, out_sat=1. Without the macro, the same stimulus gives the modulo result and out_sat=0.
